// File: rtl/tilt_player_control.sv
// Turns accelerometer X/Y samples into a saturated ship position (moved once per frame)
// and a hysteretic one-cycle fire request.
module tilt_player_control #(
   parameter int SCREEN_W    = 640,
   parameter int PLAYER_W    = 32,
   parameter int DEAD_ZONE   = 16,
   parameter int SPEED_SHIFT = 4,
   parameter int MAX_SPEED   = 8,
   parameter int FIRE_THRESH = 128
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        data_update,
   input  logic [15:0] data_x,
   input  logic [15:0] data_y,
   input  logic        frame_tick,
   output logic [9:0]  player_x,
   output logic [3:0]  speed,
   output logic        dir_left,
   output logic [15:0] avg_x,
   output logic        fire_pulse
);

   localparam logic [9:0]         X_MAX    = 10'(SCREEN_W - PLAYER_W);
   localparam logic [9:0]         X_HOME   = 10'((SCREEN_W - PLAYER_W) / 2);
   localparam logic [16:0]        DZ       = 17'(DEAD_ZONE);
   localparam logic [16:0]        SPD_CAP  = 17'(MAX_SPEED);
   localparam logic signed [15:0] FIRE_ON  = 16'(-FIRE_THRESH);
   localparam logic signed [15:0] FIRE_OFF = 16'(-(FIRE_THRESH / 2));

   typedef enum logic [1:0] {
      ARMED = 2'b01,
      FIRED = 2'b10
   } fire_state_t;

   logic [3:0][15:0]   tap;
   logic [1:0]         ptr_reg;
   logic signed [17:0] sum_reg;
   logic signed [17:0] sum_next;
   logic [16:0]        avg_ext;
   logic [16:0]        mag;
   logic [16:0]        excess;
   logic [16:0]        step_raw;
   logic [3:0]         speed_next;
   logic               dir_next;
   logic signed [10:0] pos_wide;
   logic [9:0]         pos_next;
   logic signed [15:0] data_y_s;
   fire_state_t        state_reg;
   fire_state_t        state_next;
   logic               fire_next;

   // Ring buffer of the last four X samples.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_tap
         logic [15:0] tap_reg;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               tap_reg <= '0;
            end else if (data_update && (ptr_reg == 2'(gi))) begin
               tap_reg <= data_x;
            end
         end
         assign tap[gi] = tap_reg;
      end
   endgenerate

   always_comb begin
      sum_next = sum_reg - $signed({{2{tap[ptr_reg][15]}}, tap[ptr_reg]})
                         + $signed({{2{data_x[15]}}, data_x});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_reg <= 2'd0;
         sum_reg <= '0;
      end else if (data_update) begin
         ptr_reg <= ptr_reg + 2'd1;
         sum_reg <= sum_next;
      end
   end

   assign avg_x = sum_reg[17:2];

   // 17-bit magnitude so that |-32768| is representable.
   always_comb begin
      avg_ext    = {avg_x[15], avg_x};
      mag        = avg_x[15] ? (17'd0 - avg_ext) : avg_ext;
      excess     = mag - DZ;
      step_raw   = (excess >> SPEED_SHIFT) + 17'd1;
      speed_next = 4'd0;
      if (mag > DZ) begin
         speed_next = (step_raw > SPD_CAP) ? SPD_CAP[3:0] : step_raw[3:0];
      end
      dir_next = avg_x[15] && (speed_next != 4'd0);
   end

   always_comb begin
      if (dir_left) begin
         pos_wide = $signed({1'b0, player_x}) - $signed({7'd0, speed});
      end else begin
         pos_wide = $signed({1'b0, player_x}) + $signed({7'd0, speed});
      end
      if (pos_wide < 11'sd0) begin
         pos_next = 10'd0;
      end else if (pos_wide > $signed({1'b0, X_MAX})) begin
         pos_next = X_MAX;
      end else begin
         pos_next = pos_wide[9:0];
      end
   end

   // Speed is re-registered every cycle, so a coincident frame_tick sees the old value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         player_x <= X_HOME;
         speed    <= 4'd0;
         dir_left <= 1'b0;
      end else begin
         speed    <= speed_next;
         dir_left <= dir_next;
         if (frame_tick) begin
            player_x <= pos_next;
         end
      end
   end

   assign data_y_s = $signed(data_y);

   always_comb begin
      state_next = state_reg;
      fire_next  = 1'b0;
      case (state_reg)
         ARMED: begin
            if (data_update && (data_y_s < FIRE_ON)) begin
               fire_next  = 1'b1;
               state_next = FIRED;
            end
         end
         FIRED: begin
            if (data_update && (data_y_s > FIRE_OFF)) begin
               state_next = ARMED;
            end
         end
         default: state_next = ARMED;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= ARMED;
         fire_pulse <= 1'b0;
      end else begin
         state_reg  <= state_next;
         fire_pulse <= fire_next;
      end
   end

endmodule

// File: tb/tb_tilt_player_control.sv
// Scoreboard bench for tilt_player_control: a cycle model pushes expected averages,
// fire pulses and speeds; scenario tasks pop and compare them as the DUT produces them.
module tb_tilt_player_control;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        data_update = 1'b0;
   logic [15:0] data_x = '0;
   logic [15:0] data_y = '0;
   logic        frame_tick = 1'b0;
   logic [9:0]  player_x;
   logic [3:0]  speed;
   logic        dir_left;
   logic [15:0] avg_x;
   logic        fire_pulse;

   always #5 clk = ~clk;

   tilt_player_control dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_update(data_update),
      .data_x     (data_x),
      .data_y     (data_y),
      .frame_tick (frame_tick),
      .player_x   (player_x),
      .speed      (speed),
      .dir_left   (dir_left),
      .avg_x      (avg_x),
      .fire_pulse (fire_pulse)
   );

   typedef struct {int avg; int fire;} now_t;
   typedef struct {int spd; int dir;}  late_t;

   now_t  now_q[$];
   late_t late_q[$];
   int    total = 0;
   int    bad = 0;

   int m_buf[4];
   int m_ptr, m_sum, m_px, m_speed, m_dir, m_armed;
   int pend, pend_speed, pend_dir;

   function automatic int model_speed(input int avg);
      int mag;
      int s;
      mag = (avg < 0) ? -avg : avg;
      if (mag <= 16) return 0;
      s = ((mag - 16) >> 4) + 1;
      return (s > 8) ? 8 : s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_buf[i] = 0;
      m_ptr = 0; m_sum = 0; m_px = 304; m_speed = 0; m_dir = 0; m_armed = 1;
      pend = 0; pend_speed = 0; pend_dir = 0;
      now_q.delete();
      late_q.delete();
   endtask

   // Advance one clock edge and update the reference model exactly as the edge should.
   task automatic step();
      int x, y, avg, fire;
      @(posedge clk);
      if (frame_tick) begin
         m_px = m_dir ? (m_px - m_speed) : (m_px + m_speed);
         if (m_px < 0) m_px = 0;
         if (m_px > 608) m_px = 608;
      end
      if (pend) begin
         m_speed = pend_speed; m_dir = pend_dir; pend = 0;
      end
      if (data_update) begin
         x = int'($signed(data_x));
         y = int'($signed(data_y));
         m_sum = m_sum - m_buf[m_ptr] + x;
         m_buf[m_ptr] = x;
         m_ptr = (m_ptr + 1) % 4;
         avg = m_sum >>> 2;
         fire = 0;
         if (m_armed != 0 && y < -128) begin
            fire = 1; m_armed = 0;
         end else if (m_armed == 0 && y > -64) begin
            m_armed = 1;
         end
         pend_speed = model_speed(avg);
         pend_dir = (avg < 0 && pend_speed != 0) ? 1 : 0;
         pend = 1;
         now_q.push_back('{avg, fire});
         late_q.push_back('{pend_speed, pend_dir});
         $display("update x=%0d y=%0d exp_avg=%0d exp_fire=%0d exp_speed=%0d exp_dir=%0d",
                  x, y, avg, fire, pend_speed, pend_dir);
      end
      #1;
   endtask

   task automatic drive_update(input int x, input int y);
      data_x = 16'(x);
      data_y = 16'(y);
      data_update = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (player_x !== 10'd304 || speed !== 4'd0 || dir_left !== 1'b0 ||
          avg_x !== 16'd0 || fire_pulse !== 1'b0) begin
         bad++;
         $display("FAIL reset px=%0d spd=%0d dir=%0b avg=%0d fire=%0b required 304/0/0/0/0",
                  player_x, speed, dir_left, avg_x, fire_pulse);
      end
      #2 reset_n = 1'b1;
      step();
   endtask

   task automatic test_ramp();
      int exp_spd[4] = '{1, 3, 4, 6};
      now_t  n;
      late_t l;
      for (int i = 0; i < 4; i++) begin
         drive_update(100, 0);
         step();
         data_update = 1'b0;
         n = now_q.pop_front();
         total++;
         if (avg_x !== 16'(n.avg) || fire_pulse !== n.fire[0]) begin
            bad++;
            $display("FAIL ramp_now avg=%0d fire=%0b required %0d/%0d", $signed(avg_x), fire_pulse, n.avg, n.fire);
         end
         step();
         l = late_q.pop_front();
         total++;
         if (speed !== 4'(l.spd) || dir_left !== l.dir[0] || speed !== 4'(exp_spd[i])) begin
            bad++;
            $display("FAIL ramp_speed spd=%0d dir=%0b required %0d/%0d", speed, dir_left, exp_spd[i], l.dir);
         end
      end
      for (int i = 0; i < 3; i++) begin
         frame_tick = 1'b1;
         step();
      end
      frame_tick = 1'b0;
      total++;
      if (player_x !== 10'd322 || player_x !== 10'(m_px)) begin
         bad++;
         $display("FAIL ramp_pos px=%0d required 322", player_x);
      end
   endtask

   // Four identical samples, then a run of frame ticks checked tick by tick.
   task automatic test_saturation(input int x, input int ticks, input int exp_end);
      now_t  n;
      late_t l;
      for (int i = 0; i < 4; i++) begin
         drive_update(x, 0);
         step();
         data_update = 1'b0;
         n = now_q.pop_front();
         total++;
         if (avg_x !== 16'(n.avg)) begin
            bad++;
            $display("FAIL sat_avg avg=%0d required %0d", $signed(avg_x), n.avg);
         end
         step();
         l = late_q.pop_front();
         total++;
         if (speed !== 4'(l.spd) || dir_left !== l.dir[0]) begin
            bad++;
            $display("FAIL sat_speed spd=%0d dir=%0b required %0d/%0d", speed, dir_left, l.spd, l.dir);
         end
      end
      total++;
      if (avg_x !== 16'(x) || speed !== 4'd8 || dir_left !== (x < 0)) begin
         bad++;
         $display("FAIL sat_full avg=%0d spd=%0d dir=%0b required %0d/8/%0b", $signed(avg_x), speed, dir_left, x, x < 0);
      end
      for (int i = 0; i < ticks; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         total++;
         if (player_x !== 10'(m_px) || player_x > 10'd608) begin
            bad++;
            $display("FAIL sat_tick%0d px=%0d required %0d", i, player_x, m_px);
         end
      end
      total++;
      if (player_x !== 10'(exp_end)) begin
         bad++;
         $display("FAIL sat_end px=%0d required %0d", player_x, exp_end);
      end
   endtask

   task automatic test_dead_zone();
      int xs[12] = '{16, -16, 16, -16, 16, 16, 16, 16, 17, 17, 17, 17};
      int exp_final[3] = '{0, 0, 1};
      int px_hold;
      now_t  n;
      late_t l;
      for (int i = 0; i < 12; i++) begin
         drive_update(xs[i], 0);
         step();
         data_update = 1'b0;
         n = now_q.pop_front();
         total++;
         if (avg_x !== 16'(n.avg)) begin
            bad++;
            $display("FAIL dz_avg avg=%0d required %0d", $signed(avg_x), n.avg);
         end
         step();
         l = late_q.pop_front();
         total++;
         if (speed !== 4'(l.spd) || dir_left !== l.dir[0]) begin
            bad++;
            $display("FAIL dz_speed spd=%0d dir=%0b required %0d/%0d", speed, dir_left, l.spd, l.dir);
         end
         if (i % 4 == 3) begin
            total++;
            if (speed !== 4'(exp_final[i / 4])) begin
               bad++;
               $display("FAIL dz_group%0d spd=%0d required %0d", i / 4, speed, exp_final[i / 4]);
            end
         end
         if (i == 3) begin
            px_hold = m_px;
            for (int t = 0; t < 3; t++) begin
               frame_tick = 1'b1;
               step();
               frame_tick = 1'b0;
            end
            total++;
            if (player_x !== 10'(px_hold)) begin
               bad++;
               $display("FAIL dz_hold px=%0d required %0d", player_x, px_hold);
            end
         end
      end
   endtask

   task automatic test_fire();
      int ys[5] = '{-200, -100, -100, 0, -200};
      int exp_fire[5] = '{1, 0, 0, 0, 1};
      now_t  n;
      late_t l;
      for (int i = 0; i < 5; i++) begin
         drive_update(0, ys[i]);
         step();
         data_update = 1'b0;
         n = now_q.pop_front();
         total++;
         if (fire_pulse !== n.fire[0] || fire_pulse !== exp_fire[i][0]) begin
            bad++;
            $display("FAIL fire_upd%0d fire=%0b required %0d", i, fire_pulse, exp_fire[i]);
         end
         step();
         l = late_q.pop_front();
         total++;
         if (fire_pulse !== 1'b0 || speed !== 4'(l.spd)) begin
            bad++;
            $display("FAIL fire_width%0d fire=%0b spd=%0d required 0/%0d", i, fire_pulse, speed, l.spd);
         end
      end
   endtask

   task automatic test_back_to_back();
      int xs[6] = '{200, -300, 50, 1000, -20, 0};
      int ys[6] = '{-200, -200, -300, 0, -150, -150};
      now_t  n;
      late_t l;
      for (int i = 0; i < 6; i++) begin
         drive_update(xs[i], ys[i]);
         step();
         n = now_q.pop_front();
         total++;
         if (avg_x !== 16'(n.avg) || fire_pulse !== n.fire[0]) begin
            bad++;
            $display("FAIL b2b_now%0d avg=%0d fire=%0b required %0d/%0d", i, $signed(avg_x), fire_pulse, n.avg, n.fire);
         end
         if (i > 0) begin
            l = late_q.pop_front();
            total++;
            if (speed !== 4'(l.spd) || dir_left !== l.dir[0]) begin
               bad++;
               $display("FAIL b2b_speed%0d spd=%0d dir=%0b required %0d/%0d", i, speed, dir_left, l.spd, l.dir);
            end
         end
      end
      data_update = 1'b0;
      step();
      l = late_q.pop_front();
      total++;
      if (speed !== 4'(l.spd) || dir_left !== l.dir[0] || fire_pulse !== 1'b0) begin
         bad++;
         $display("FAIL b2b_last spd=%0d dir=%0b fire=%0b required %0d/%0d/0", speed, dir_left, fire_pulse, l.spd, l.dir);
      end
   endtask

   task automatic test_simultaneous_and_reset();
      int px_before, spd_before, dir_before, exp_px;
      now_t  n;
      late_t l;
      drive_update(-512, 0);
      step();
      data_update = 1'b0;
      n = now_q.pop_front();
      px_before = m_px; spd_before = m_speed; dir_before = m_dir;
      exp_px = dir_before ? px_before - spd_before : px_before + spd_before;
      if (exp_px < 0) exp_px = 0;
      if (exp_px > 608) exp_px = 608;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      l = late_q.pop_front();
      total++;
      if (player_x !== 10'(exp_px) || speed !== 4'(l.spd)) begin
         bad++;
         $display("FAIL simul_old_speed px=%0d spd=%0d required %0d/%0d", player_x, speed, exp_px, l.spd);
      end
      for (int i = 0; i < 3; i++) begin
         drive_update(-512, -300);
         frame_tick = 1'b1;
         step();
         data_update = 1'b0;
         frame_tick = 1'b0;
         n = now_q.pop_front();
         total++;
         if (avg_x !== 16'(n.avg) || fire_pulse !== n.fire[0] || player_x !== 10'(m_px)) begin
            bad++;
            $display("FAIL simul_both%0d avg=%0d fire=%0b px=%0d required %0d/%0d/%0d",
                     i, $signed(avg_x), fire_pulse, player_x, n.avg, n.fire, m_px);
         end
         step();
         l = late_q.pop_front();
      end
      total++;
      if (speed !== 4'd8 || dir_left !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset spd=%0d dir=%0b required 8/1", speed, dir_left);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (player_x !== 10'd304 || speed !== 4'd0 || dir_left !== 1'b0 ||
          avg_x !== 16'd0 || fire_pulse !== 1'b0) begin
         bad++;
         $display("FAIL async_reset px=%0d spd=%0d dir=%0b avg=%0d fire=%0b required 304/0/0/0/0",
                  player_x, speed, dir_left, avg_x, fire_pulse);
      end
      model_reset();
      @(posedge clk);
      #3 reset_n = 1'b1;
      step();
      drive_update(100, -200);
      step();
      data_update = 1'b0;
      n = now_q.pop_front();
      total++;
      if (avg_x !== 16'(n.avg) || avg_x !== 16'd25 || fire_pulse !== 1'b1) begin
         bad++;
         $display("FAIL post_reset avg=%0d fire=%0b required 25/1", $signed(avg_x), fire_pulse);
      end
      step();
      l = late_q.pop_front();
      total++;
      if (speed !== 4'(l.spd) || speed !== 4'd1) begin
         bad++;
         $display("FAIL post_reset_speed spd=%0d required 1", speed);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_saturation(-512, 45, 0);
      test_saturation(512, 80, 608);
      test_dead_zone();
      test_fire();
      test_back_to_back();
      test_simultaneous_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
